seg7_scan_display: RTL
======================

// Module: seg7_scan_display
// PURPOSE
//  Downstream consumer of the UART receiver's byte/ready output. Builds a 4-digit display buffer from the received bytes.
//  Drives a time-multiplexed 4-digit 7-segment display with a refresh counter and an anti-ghosting blank gap.
//  Sits between the UART RX stage and the board's segment/digit-enable pins.
// PARAMETERS
//  SCAN_DIV        6750  clocks per digit slot (27 MHz / 6750 / 4 digits = 1 kHz frame); must be > GHOST_CYC
//  GHOST_CYC       16    clocks at the start of each slot with all digits disabled
//  DIGIT_ACT_LOW   1     1: digit_en is active-low; 0: digit_en is active-high
// PORTS
//  clk        in   1  system clock (27 MHz)
//  reset_n    in   1  asynchronous reset, active-low
//  rx_data    in   8  received byte; valid while rx_valid is high
//  rx_valid   in   1  byte-ready indication; a level or a pulse; only the rising edge is used
//  seg        out  7  segments {g,f,e,d,c,b,a}, active-high, registered
//  digit_en   out  4  one-hot digit select; bit0 = rightmost digit; registered; polarity set by DIGIT_ACT_LOW
//  bad_byte   out  1  1-cycle pulse when an accepted byte is unrecognised
//  rx_count   out  8  count of accepted bytes; wraps 255->0
// BEHAVIOUR
//  Clock and reset:
//  - Reset is asynchronous, active-low, on reset_n; the clock is clk.
//  Reset state:
//  - buf[3:0] = BLANK (4'hF); slot index = 0; div counter = 0; rx_valid_q = 0.
//  - seg = 0; digit_en = all inactive; bad_byte = 0; rx_count = 0.
//  - Reset mid-frame or mid-byte clears everything immediately; no partial update survives.
//  Byte acceptance:
//  - A byte is accepted when rx_valid & ~rx_valid_q. A held rx_valid level accepts exactly one byte.
//  Byte decode (the buffer is updated on the same clock edge that accepts the byte):
//  - 0x00-0x09 or 0x30-0x39: buf <= {buf[2:0], value}. The new digit enters at the right.
//  - 0x2D '-': shift in DASH (4'hA).
//  - 0x43 / 0x63 'C'/'c': all buf = BLANK.
//  - Any other value: buf unchanged; bad_byte = 1 on the next cycle.
//  - rx_count increments for every accepted byte, including bad bytes.
//  Cell codes:
//  - 0-9 digit; A dash (segment g only); F blank (seg = 0). Codes B-E are unused and display blank.
//  Scan state machine:
//  - Two phases per slot: GAP (div < GHOST_CYC) and ON (div >= GHOST_CYC).
//  - div counts 0..SCAN_DIV-1. At SCAN_DIV-1 it wraps to 0 and the slot index advances 0->1->2->3->0.
//  - GAP: digit_en all inactive; seg = 0.
//  - ON: digit_en[slot] active; seg = decode(buf[slot]).
//  - Outputs are registered: they reflect the counter/buffer state one cycle later.
//  Simultaneous events:
//  - A byte accepted during an ON phase changes seg on the cycle after the buffer update.
//  - The scan timing is never stalled or reset by byte traffic.
// CONFIGURATION
//  SEG_LZ_BLANK_EN defined:
//  - Leading-zero blanking. Digits 3..1 holding 0 display blank while every digit to their left is 0 or BLANK.
//  - Digit 0 always displays.
//  - buf contents are unaffected; only the decode path changes.
//  SEG_LZ_BLANK_EN undefined:
//  - All cells display their code as stored.
// STRUCTURE
//  seg7_pkg:
//  - Cell-code constants CODE_DASH=4'hA and CODE_BLANK=4'hF.
//  - Segment patterns SEG_0..SEG_9, SEG_DASH=7'b1000000, SEG_OFF=7'b0.
//  - Byte constants CHR_DASH, CHR_CLR_U, CHR_CLR_L.
//  seg7_decode sub-module:
//  - Combinational 4-bit cell code -> 7-bit segment LUT, instantiated once on the selected cell.
//  Top level:
//  - Edge detect, buffer, scan counter/FSM and output registers.
// TESTING
//  Bench settings: SCAN_DIV=8, GHOST_CYC=2, DIGIT_ACT_LOW=1.
//  - Reset release: seg=0, digit_en=4'b1111, rx_count=0.
//    One frame (32 clk) shows every slot blank.
//  - Bytes '1','2','3','4' (0x31..0x34) as single pulses:
//    slot0 seg=SEG_4 with digit_en=4'b1110; slot3 seg=SEG_1 with digit_en=4'b0111; rx_count=4.
//  - rx_valid held high for 50 clk with 0x07: only one shift occurs; rx_count increments by 1.
//  - Byte 0x41 'A': bad_byte pulses for exactly 1 clk; buffer unchanged; rx_count increments.
//  - '-' followed by 'c':
//    dash appears in slot0 (seg=7'b1000000); then all slots blank.
//  - SEG_LZ_BLANK_EN with bytes 0x00,0x00,0x00,0x00:
//    slots 3..1 blank; slot0 shows SEG_0.
//  - Reset asserted mid-slot: all outputs return to reset values asynchronously, without waiting for a clock edge.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: cell codes, segment patterns, byte constants and byte classification for the scan display
// Macro: none (leading-zero blanking, SEG_LZ_BLANK_EN, lives in seg7_scan_display)
package seg7_pkg;
   localparam logic [3:0] CODE_DASH  = 4'hA;
   localparam logic [3:0] CODE_BLANK = 4'hF;
   // Segment order {g,f,e,d,c,b,a}, active-high
   localparam logic [6:0] SEG_0    = 7'h3F;
   localparam logic [6:0] SEG_1    = 7'h06;
   localparam logic [6:0] SEG_2    = 7'h5B;
   localparam logic [6:0] SEG_3    = 7'h4F;
   localparam logic [6:0] SEG_4    = 7'h66;
   localparam logic [6:0] SEG_5    = 7'h6D;
   localparam logic [6:0] SEG_6    = 7'h7D;
   localparam logic [6:0] SEG_7    = 7'h07;
   localparam logic [6:0] SEG_8    = 7'h7F;
   localparam logic [6:0] SEG_9    = 7'h6F;
   localparam logic [6:0] SEG_DASH = 7'b1000000;
   localparam logic [6:0] SEG_OFF  = 7'b0000000;
   localparam logic [7:0] CHR_DASH  = 8'h2D;
   localparam logic [7:0] CHR_CLR_U = 8'h43;
   localparam logic [7:0] CHR_CLR_L = 8'h63;
   typedef enum logic [1:0] {BYTE_DIGIT, BYTE_DASH, BYTE_CLR, BYTE_BAD} byte_kind_t;
   typedef enum logic {PH_GAP, PH_ON} phase_t;
   // Raw 0x00-0x09 and ASCII '0'-'9' both carry the digit value in the low nibble
   function automatic byte_kind_t byte_kind(input logic [7:0] b);
      return (b <= 8'h09 || (b >= 8'h30 && b <= 8'h39)) ? BYTE_DIGIT :
             (b == CHR_DASH)                           ? BYTE_DASH  :
             (b == CHR_CLR_U || b == CHR_CLR_L)         ? BYTE_CLR   : BYTE_BAD;
   endfunction
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational cell code to 7-segment pattern lookup
// Ports: code_i [3:0] cell code (0-9 digit, A dash, others blank)
//        seg_o  [6:0] segments {g,f,e,d,c,b,a}, active-high
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [3:0] code_i,
   output logic [6:0] seg_o
);
   always_comb begin
      seg_o = SEG_OFF;
      case (code_i)
         4'd0:      seg_o = SEG_0;
         4'd1:      seg_o = SEG_1;
         4'd2:      seg_o = SEG_2;
         4'd3:      seg_o = SEG_3;
         4'd4:      seg_o = SEG_4;
         4'd5:      seg_o = SEG_5;
         4'd6:      seg_o = SEG_6;
         4'd7:      seg_o = SEG_7;
         4'd8:      seg_o = SEG_8;
         4'd9:      seg_o = SEG_9;
         CODE_DASH: seg_o = SEG_DASH;
         default:   seg_o = SEG_OFF;
      endcase
   end
endmodule

// File: rtl/seg7_scan_display.sv
// seg7_scan_display: builds a 4-digit buffer from UART bytes and scans it onto a multiplexed 7-segment display
// Macro: SEG_LZ_BLANK_EN enables leading-zero blanking of digits 3..1 (display path only)
// Ports: clk          system clock
//        reset_n      asynchronous reset, active-low
//        rx_data[7:0] received byte, valid while rx_valid is high
//        rx_valid     byte ready; only its rising edge accepts a byte
//        seg[6:0]     segments {g,f,e,d,c,b,a}, active-high, registered
//        digit_en[3:0] one-hot digit select, bit0 rightmost, polarity from DIGIT_ACT_LOW
//        bad_byte     1-cycle pulse after an unrecognised accepted byte
//        rx_count[7:0] accepted byte count, wraps
module seg7_scan_display
   import seg7_pkg::*;
#(
   parameter int SCAN_DIV      = 6750,
   parameter int GHOST_CYC     = 16,
   parameter bit DIGIT_ACT_LOW = 1'b1
)(
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic [6:0] seg,
   output logic [3:0] digit_en,
   output logic       bad_byte,
   output logic [7:0] rx_count
);
   localparam int             DW      = $clog2(SCAN_DIV);
   localparam logic [DW-1:0]  DIV_MAX = DW'(SCAN_DIV - 1);
   localparam logic [DW-1:0]  GAP_END = DW'(GHOST_CYC);
   localparam logic [3:0]     EN_OFF  = DIGIT_ACT_LOW ? 4'hF : 4'h0;

   logic [3:0][3:0] cells_q, cells_d;
   logic [DW-1:0]   div_q, div_d;
   logic [1:0]      slot_q, slot_d;
   phase_t          phase_q, phase_d;
   logic            rx_valid_q;
   logic [6:0]      seg_q, seg_d;
   logic [3:0]      digit_en_q, digit_en_d;
   logic            bad_byte_q, bad_byte_d;
   logic [7:0]      rx_count_q, rx_count_d;
   logic            accept, wrap, on;
   byte_kind_t      kind;
   logic [3:0]      lz_mask, cell_sel;
   logic [6:0]      seg_dec;

`ifdef SEG_LZ_BLANK_EN
   logic zb3, zb2;
   // A zero is "leading" while everything to its left is zero or blank
   assign zb3     = cells_q[3] == 4'h0 || cells_q[3] == CODE_BLANK;
   assign zb2     = cells_q[2] == 4'h0 || cells_q[2] == CODE_BLANK;
   assign lz_mask = {cells_q[3] == 4'h0, cells_q[2] == 4'h0 && zb3, cells_q[1] == 4'h0 && zb3 && zb2, 1'b0};
`else
   assign lz_mask = 4'b0000;
`endif

   assign cell_sel = lz_mask[slot_q] ? CODE_BLANK : cells_q[slot_q];

   seg7_decode u_dec (
      .code_i (cell_sel),
      .seg_o  (seg_dec)
   );

   always_comb begin
      accept     = rx_valid & ~rx_valid_q;
      kind       = byte_kind(rx_data);
      cells_d    = !accept                ? cells_q :
                   (kind == BYTE_DIGIT)   ? {cells_q[2:0], rx_data[3:0]} :
                   (kind == BYTE_DASH)    ? {cells_q[2:0], CODE_DASH} :
                   (kind == BYTE_CLR)     ? {4{CODE_BLANK}} : cells_q;
      bad_byte_d = accept && kind == BYTE_BAD;
      rx_count_d = rx_count_q + {7'd0, accept};
      wrap       = div_q == DIV_MAX;
      div_d      = wrap ? '0 : div_q + 1'b1;
      slot_d     = wrap ? slot_q + 2'd1 : slot_q;
      phase_d    = (div_d < GAP_END) ? PH_GAP : PH_ON;
      on         = phase_q == PH_ON;
      seg_d      = on ? seg_dec : SEG_OFF;
      // XOR with the idle pattern gives the correct polarity for either pin sense
      digit_en_d = EN_OFF ^ (on ? 4'b0001 << slot_q : 4'b0000);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cells_q    <= {4{CODE_BLANK}};
         div_q      <= '0;
         slot_q     <= 2'd0;
         phase_q    <= PH_GAP;
         rx_valid_q <= 1'b0;
         seg_q      <= SEG_OFF;
         digit_en_q <= EN_OFF;
         bad_byte_q <= 1'b0;
         rx_count_q <= 8'd0;
      end else begin
         cells_q    <= cells_d;
         div_q      <= div_d;
         slot_q     <= slot_d;
         phase_q    <= phase_d;
         rx_valid_q <= rx_valid;
         seg_q      <= seg_d;
         digit_en_q <= digit_en_d;
         bad_byte_q <= bad_byte_d;
         rx_count_q <= rx_count_d;
      end
   end

   assign seg      = seg_q;
   assign digit_en = digit_en_q;
   assign bad_byte = bad_byte_q;
   assign rx_count = rx_count_q;
endmodule
